// File: rtl/sha_result_checker_pkg.sv
// Shared types for the SHA result path: digest state, checker FSM states,
// the buffered result record and the digest byte-swap helper.
package sha_result_checker_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } checker_state_e;

  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] word;
  } CheckResult;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO of CheckResult records with flush and drop-on-full reporting.
// Flush empties the FIFO first, then a same-cycle push is still accepted.
module result_fifo2
  import sha_result_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  CheckResult din,
  input  logic       pop,
  output CheckResult dout,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  CheckResult mem [2];
  logic [1:0] cnt;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_pop;
  logic       accept;

  assign empty  = (cnt == 2'd0);
  assign full   = (cnt == 2'd2);
  assign do_pop = pop & ~empty;
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign accept = push & (~full | do_pop);
  assign drop   = push & full & ~do_pop & ~flush;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      if (push) begin
        mem[0] <= din;
        wr_ptr <= 1'b1;
        cnt    <= 2'd1;
      end else begin
        wr_ptr <= 1'b0;
        cnt    <= 2'd0;
      end
    end else begin
      if (accept) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, accept} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/sha_result_checker.sv
// Checks double-SHA digests against the difficulty target and queues winning nonces.
// Define CHECKER_FIRST_ONLY_EN to report only the first winner of each block.
module sha_result_checker
  import sha_result_checker_pkg::*;
#(
  parameter logic [31:0] PROCESSORINDEX = 32'd0,
  parameter logic [31:0] NUMPROCESSORS  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        newblock_i,
  input  HashState    hash_i,
  input  logic [31:0] difficulty_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_nonce_o,
  output logic [31:0] result_word_o,
  output logic        overflow_o,
  output logic [31:0] count_o
);

`ifdef CHECKER_FIRST_ONLY_EN
  localparam bit FIRST_ONLY = 1'b1;
`else
  localparam bit FIRST_ONLY = 1'b0;
`endif

  checker_state_e state;
  logic [31:0]    n;
  logic [31:0]    top;
  logic [31:0]    cur_nonce;
  logic           s1_valid;
  logic           s1_pass;
  logic           s1_newblock;
  logic [31:0]    s1_nonce;
  logic [31:0]    s1_word;
  logic           s1_nb;
  logic           push;
  logic           drop;
  logic           fifo_empty;
  logic           fifo_full_unused;
  logic           unused_hash_bits;
  CheckResult     head;

  assign top       = bswap32(hash_i.h);
  assign cur_nonce = newblock_i ? PROCESSORINDEX : n;
  assign unused_hash_bits = ^{hash_i.a, hash_i.b, hash_i.c, hash_i.d,
                              hash_i.e, hash_i.f, hash_i.g};

  always_ff @(posedge clk) begin
    if (rst) begin
      n           <= PROCESSORINDEX;
      s1_valid    <= 1'b0;
      s1_pass     <= 1'b0;
      s1_newblock <= 1'b0;
      s1_nonce    <= '0;
      s1_word     <= '0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_pass     <= (top <= difficulty_i);
        s1_newblock <= newblock_i;
        s1_nonce    <= cur_nonce;
        s1_word     <= top;
        n           <= cur_nonce + NUMPROCESSORS;
      end
    end
  end

  // The newblock hash itself is evaluated as part of the new search.
  assign s1_nb = s1_valid & s1_newblock;
  assign push  = s1_pass & (s1_nb | (s1_valid & (state == SEARCH)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (s1_nb) begin
        state <= (FIRST_ONLY && s1_pass) ? DONE : SEARCH;
      end else if (FIRST_ONLY && push) begin
        state <= DONE;
      end

      if (s1_nb) begin
        count_o <= 32'd1;
      end else if (s1_valid && (state != IDLE) && (count_o != '1)) begin
        count_o <= count_o + 32'd1;
      end

      overflow_o <= s1_nb ? 1'b0 : (overflow_o | drop);
    end
  end

  result_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (s1_nb),
    .push  (push),
    .din   ('{nonce: s1_nonce, word: s1_word}),
    .pop   (result_valid_o & result_ready_i),
    .dout  (head),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .drop  (drop)
  );

  assign result_valid_o = ~fifo_empty;
  assign result_nonce_o = head.nonce;
  assign result_word_o  = head.word;

endmodule

// File: doc/sha_result_checker.md
# sha_result_checker

Sits directly downstream of `sha_last_pipelined_core` in each processor slice and consumes its `doublehash`, `output_valid`, `newblock_o` and `difficulty` outputs. For every valid double hash it reconstructs the nonce that produced it and compares the hash against the difficulty target. Winning nonces are queued in a 2-entry result buffer and drained over a valid/ready handshake toward the host-side collector.

## Interface
Parameters:
- PROCESSORINDEX, 0, index of this slice; the nonce of the first hash of a block.
- NUMPROCESSORS, 1, nonce stride between consecutive hashes of this slice.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- valid_i  in  1  hash_i/newblock_i/difficulty_i qualify this cycle.
- newblock_i  in  1  this hash is the first of a new block.
- hash_i  in  HashState  double SHA-256 digest.
- difficulty_i  in  32  target for the top digest word.
- result_valid_o  out  1  buffer head holds a winning nonce.
- result_ready_i  in  1  consumer accepts the head this cycle.
- result_nonce_o  out  32  winning nonce.
- result_word_o  out  32  byte-swapped H7 of the winning hash.
- overflow_o  out  1  sticky; a winner was dropped because the buffer was full.
- count_o  out  32  valid hashes checked in the current block.

## Operation
- Top word: `top = bswap32(hash_i.h)`. H7 is the most significant word of Bitcoin's little-endian digest.
- Pass condition: `top <= difficulty_i`, unsigned.
- Nonce counter `n`, 32-bit:
  - On `valid_i & newblock_i`, the hash's nonce is PROCESSORINDEX, and `n` becomes PROCESSORINDEX+NUMPROCESSORS.
  - On `valid_i & !newblock_i`, the hash's nonce is `n`, and `n` increments by NUMPROCESSORS.
  - Arithmetic wraps modulo 2^32.
- State machine:
  - IDLE: entered at reset. Every valid hash is ignored.
  - SEARCH: checks hashes.
  - DONE: only reachable with the configuration macro.
  - Transitions: `valid_i & newblock_i` moves IDLE, SEARCH or DONE to SEARCH.
- Stage register (S1) holds pass flag, nonce, top word and newblock flag.
- Result buffer (2-entry FIFO):
  - An S1 pass in SEARCH pushes an entry.
  - A handshake (`result_valid_o & result_ready_i`) pops the head.
  - Push and pop in the same cycle while full is accepted: no overflow.
  - Push while full with no pop drops the entry and sets `overflow_o`.
- New block reaching S1:
  - Flushes the buffer and clears `overflow_o` first.
  - Then applies that hash's own push, so the new block's first winner is kept.
- `count_o`:
  - Set to 1 by a newblock hash at S1.
  - Incremented by each other valid S1 hash in SEARCH or DONE.
  - Saturates at 0xFFFFFFFF.

## Timing
- Latency from input to S1 is 1 cycle. A winner presented at cycle t shows `result_valid_o` at t+2 when the buffer was empty.
- `result_ready_i` is used combinationally only to pop. No output depends combinationally on any input.
- `result_*` outputs hold stable while `result_valid_o & !result_ready_i`.
- Reset values: `result_valid_o`=0, `result_nonce_o`=0, `result_word_o`=0, `overflow_o`=0, `count_o`=0, state IDLE, `n`=PROCESSORINDEX, S1 invalid, buffer empty.
- Reset asserted mid-operation discards S1 and all buffer contents in the same cycle.
- Back-to-back valid inputs are sustained with no bubbles. The block never stalls upstream, because the core has no backpressure.

## Configuration
- `CHECKER_FIRST_ONLY_EN` defined:
  - The first pass in SEARCH pushes its entry and moves to DONE.
  - In DONE, further passes are ignored, and `count_o` still counts.
  - Only the next newblock returns to SEARCH.
- Undefined:
  - DONE is never entered, and every pass is pushed.

## Structure
- Shared package (sha package, alongside HashState) holds:
  - the state enum (IDLE/SEARCH/DONE);
  - a `bswap32` function;
  - a `CheckResult` struct {nonce, word}.
- One natural sub-module: `result_fifo2`. It is a 2-entry FIFO of CheckResult with push/pop, flush, full/empty, and drop-on-full reporting. It is reused by the host collector.

## Test plan
- Block with PROCESSORINDEX=3, NUMPROCESSORS=4, difficulty 0xFFFFFFFF, 3 hashes:
  - nonces 3, 7, 11 appear in order with ready held high;
  - `count_o`=3.
- difficulty 0x00000FFF; the hash with H7=0x00010000 (bswap 0x00000100) passes and the hash with H7=0x00000001 (bswap 0x01000000) fails:
  - exactly one result, with `result_word_o`=0x00000100.
- `result_ready_i` held low while 3 winners arrive:
  - 2 buffered;
  - `overflow_o`=1;
  - the head stays stable;
  - a subsequent newblock clears `overflow_o` and flushes the buffer.
- Nonce wrap with PROCESSORINDEX=0, NUMPROCESSORS=0x80000000:
  - nonces 0, 0x80000000, 0;
  - then hashes in IDLE after reset produce no results.
- With `CHECKER_FIRST_ONLY_EN` and 4 consecutive winners:
  - a single result, for the first nonce;
  - the next newblock re-enables reporting.
- `rst` pulsed while the buffer holds 2 entries:
  - the next cycle shows `result_valid_o`=0 and `count_o`=0.
